// File: rtl/maxnet_controller.sv
// Sequencer for a 4-input PU running synchronous Maxnet until at most one activation survives.
// Optional iteration cap with timeout when MAXNET_ITER_LIMIT_EN is defined.
`timescale 1ns/1ps
module maxnet_controller #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] EPSILON  = 32'h3E4CCCCD,
  parameter int              MAX_ITER = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a_in0,
  input  logic [XLEN-1:0] a_in1,
  input  logic [XLEN-1:0] a_in2,
  input  logic [XLEN-1:0] a_in3,
  output logic [XLEN-1:0] pu_num1,
  output logic [XLEN-1:0] pu_num2,
  output logic [XLEN-1:0] pu_num3,
  output logic [XLEN-1:0] pu_num4,
  output logic [XLEN-1:0] pu_w1,
  output logic [XLEN-1:0] pu_w2,
  output logic [XLEN-1:0] pu_w3,
  output logic [XLEN-1:0] pu_w4,
  output logic            pu_l1,
  output logic            pu_l2,
  output logic            pu_l3,
  input  logic [XLEN-1:0] pu_result,
  output logic            busy,
  output logic            done,
  output logic [1:0]      winner,
  output logic [XLEN-1:0] win_value,
  output logic            no_winner,
  output logic            timeout
);
  localparam logic [XLEN-1:0] ONE     = XLEN'(32'h3F800000);
  localparam logic [XLEN-1:0] NEG_EPS = {1'b1, EPSILON[XLEN-2:0]};
  localparam int              ITER_W  = $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, UPDATE, CHECK, FIN} state_t;

  state_t                  state;
  logic [2:0]              ph;
  logic [1:0]              cap;
  logic [ITER_W-1:0]       iter;
  logic [3:0][XLEN-1:0]    a, n, a_ins, src, ops;
  logic [1:0]              k_nxt, nz_idx;
  logic [2:0]              nz_cnt;
  logic                    cap_hit, cont, load;

  function automatic logic [XLEN-1:0] relu(input logic [XLEN-1:0] x);
    return (x[XLEN-1] || x[XLEN-2 -: 8] == 8'd0) ? '0 : x;
  endfunction

  // Slot 1 carries the neuron itself; slots 2..4 the others in ascending index order.
  function automatic logic [3:0][XLEN-1:0] issue_nums(input logic [1:0] k,
                                                      input logic [3:0][XLEN-1:0] v);
    logic [3:0][XLEN-1:0] r;
    r[0] = v[k];
    for (int j = 0; j < 3; j++) r[j+1] = (2'(j) < k) ? v[j] : v[j+1];
    return r;
  endfunction

  assign a_ins = {a_in3, a_in2, a_in1, a_in0};

  always_comb begin
    src    = (state == IDLE) ? a_ins : a;
    k_nxt  = (state == ISSUE) ? ph[1:0] + 2'd1 : 2'd0;
    ops    = issue_nums(k_nxt, src);
    nz_cnt = '0;
    nz_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (a[i][XLEN-2 -: 8] != 8'd0) begin
        nz_cnt = nz_cnt + 3'd1;
        nz_idx = 2'(i);
      end
    end
  end

`ifdef MAXNET_ITER_LIMIT_EN
  logic [1:0] max_idx;
  always_comb begin
    max_idx = '0;
    for (int i = 1; i < 4; i++) if (a[i] > a[max_idx]) max_idx = 2'(i);
  end
  assign cap_hit = (iter == ITER_W'(MAX_ITER));
`else
  assign cap_hit = 1'b0;
`endif

  assign cont = (nz_cnt >= 3'd2) && !cap_hit;
  assign load = (state == IDLE && start) || (state == ISSUE && ph < 3'd3) ||
                (state == CHECK && cont);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;  ph <= '0;  cap <= '0;  iter <= '0;
      a <= '0;  n <= '0;
      pu_num1 <= '0;  pu_num2 <= '0;  pu_num3 <= '0;  pu_num4 <= '0;
      pu_w1 <= '0;  pu_w2 <= '0;  pu_w3 <= '0;  pu_w4 <= '0;
      pu_l1 <= 1'b0;  pu_l2 <= 1'b0;  pu_l3 <= 1'b0;
      busy <= 1'b0;  done <= 1'b0;  winner <= '0;  win_value <= '0;
      no_winner <= 1'b0;  timeout <= 1'b0;
    end else begin
      // The PU pipeline is fixed, so l2/l3 are simply l1 delayed.
      pu_l1 <= load;
      pu_l2 <= pu_l1;
      pu_l3 <= pu_l2;
      done  <= 1'b0;
      if (load) begin
        pu_num1 <= ops[0];  pu_num2 <= ops[1];  pu_num3 <= ops[2];  pu_num4 <= ops[3];
        pu_w1 <= ONE;  pu_w2 <= NEG_EPS;  pu_w3 <= NEG_EPS;  pu_w4 <= NEG_EPS;
      end
      case (state)
        IDLE: if (start) begin
          a <= a_ins;  busy <= 1'b1;  iter <= '0;  ph <= '0;  cap <= '0;
          winner <= '0;  win_value <= '0;  no_winner <= 1'b0;  timeout <= 1'b0;
          state <= ISSUE;
        end
        ISSUE: begin
          if (pu_l3) begin
            n[cap] <= relu(pu_result);
            cap    <= cap + 2'd1;
          end
          if (ph == 3'd5) state <= UPDATE;
          else            ph    <= ph + 3'd1;
        end
        UPDATE: begin
          a     <= n;
          iter  <= iter + 1'b1;
          state <= CHECK;
        end
        CHECK: begin
          if (nz_cnt == 3'd1) begin
            winner <= nz_idx;  win_value <= a[nz_idx];
          end else if (nz_cnt == 3'd0) begin
            no_winner <= 1'b1;  winner <= '0;  win_value <= '0;
`ifdef MAXNET_ITER_LIMIT_EN
          end else if (cap_hit) begin
            timeout <= 1'b1;  winner <= max_idx;  win_value <= a[max_idx];
`endif
          end
          if (cont) begin
            ph <= '0;  cap <= '0;  state <= ISSUE;
          end else begin
            done <= 1'b1;  busy <= 1'b0;  state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
